// File: rtl/anita3_trigger_pattern_buffer_if.sv
// Trigger-side and readout-side signals of the trigger pattern buffer.
// The slave modport is the buffer itself; master is whoever drives it.
interface anita3_trigger_pattern_buffer_if #(
  parameter int NUM_PHI   = 16,
  parameter int DEPTH     = 4,
  parameter int TS_BITS   = 32,
  parameter int TNUM_BITS = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                   trig_i;
  logic [2*NUM_PHI-1:0]   phi_i;
  logic                   clear_i;
  logic                   rd_i;
  logic                   valid_o;
  logic [2*NUM_PHI-1:0]   pattern_o;
  logic [TS_BITS-1:0]     timestamp_o;
  logic [TNUM_BITS-1:0]   trig_num_o;
  logic [CW-1:0]          count_o;
  logic                   overflow_o;
  logic [TNUM_BITS-1:0]   dropped_o;

  modport slave (
    input  trig_i, phi_i, clear_i, rd_i,
    output valid_o, pattern_o, timestamp_o, trig_num_o, count_o, overflow_o, dropped_o
  );

  modport master (
    output trig_i, phi_i, clear_i, rd_i,
    input  valid_o, pattern_o, timestamp_o, trig_num_o, count_o, overflow_o, dropped_o
  );
endinterface

// File: rtl/anita3_trigger_pattern_buffer.sv
// Timestamps and numbers each rising trigger edge and queues {phi pattern, timestamp,
// trigger number} in a first-word-fall-through FIFO; drops are counted, not lost silently.
module anita3_trigger_pattern_buffer #(
  parameter int NUM_PHI   = 16,
  parameter int DEPTH     = 4,
  parameter int TS_BITS   = 32,
  parameter int TNUM_BITS = 16
) (
  input  logic clk250_i,
  input  logic rst_n_i,
  anita3_trigger_pattern_buffer_if.slave bus
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int PAT = 2 * NUM_PHI;

  logic [TS_BITS-1:0]   ts;
  logic [TNUM_BITS-1:0] tnum;
  logic [TNUM_BITS-1:0] dropped;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 overflow;
  logic                 trig_d;
  logic                 armed;

  logic [PAT-1:0]       pat_mem [DEPTH];
  logic [TS_BITS-1:0]   ts_mem  [DEPTH];
  logic [TNUM_BITS-1:0] tn_mem  [DEPTH];

  logic det, full, pop, wr_en, drop;

  // armed stays low after reset until trig_i has been seen low, so a level that
  // was already high when reset released never counts as a fresh edge.
  always_comb begin
    det   = bus.trig_i & ~trig_d & armed;
    full  = (count == CW'(DEPTH));
    pop   = bus.rd_i & (count != '0);
    wr_en = det & (~full | pop);
    drop  = det & full & ~pop;
  end

  always_ff @(posedge clk250_i) begin
    if (!rst_n_i) begin
      ts       <= '0;
      tnum     <= '0;
      dropped  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      trig_d   <= 1'b0;
      armed    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pat_mem[i] <= '0;
        ts_mem[i]  <= '0;
        tn_mem[i]  <= '0;
      end
    end else begin
      ts     <= ts + TS_BITS'(1);
      trig_d <= bus.trig_i;
      armed  <= armed | ~bus.trig_i;
      if (bus.clear_i) begin
        tnum     <= '0;
        dropped  <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (wr_en) begin
          pat_mem[wr_ptr] <= bus.phi_i;
          ts_mem[wr_ptr]  <= ts;
          tn_mem[wr_ptr]  <= tnum;
          wr_ptr          <= wr_ptr + PW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        case ({wr_en, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
        // Trigger number advances even on a drop so gaps reveal lost triggers.
        if (det)
          tnum <= tnum + TNUM_BITS'(1);
        if (drop) begin
          overflow <= 1'b1;
          if (dropped != '1)
            dropped <= dropped + TNUM_BITS'(1);
        end
      end
    end
  end

  assign bus.valid_o     = (count != '0);
  assign bus.pattern_o   = pat_mem[rd_ptr];
  assign bus.timestamp_o = ts_mem[rd_ptr];
  assign bus.trig_num_o  = tn_mem[rd_ptr];
  assign bus.count_o     = count;
  assign bus.overflow_o  = overflow;
  assign bus.dropped_o   = dropped;
endmodule

// File: tb/tb_anita3_trigger_pattern_buffer.sv
// Directed bench for the trigger pattern buffer; inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_anita3_trigger_pattern_buffer;
  logic clk250 = 1'b0;
  logic rst_n  = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [31:0] tb_ts;

  anita3_trigger_pattern_buffer_if #(.NUM_PHI(16), .DEPTH(4), .TS_BITS(32), .TNUM_BITS(16)) bus ();

  anita3_trigger_pattern_buffer #(.NUM_PHI(16), .DEPTH(4), .TS_BITS(32), .TNUM_BITS(16)) dut (
    .clk250_i (clk250),
    .rst_n_i  (rst_n),
    .bus      (bus.slave)
  );

  always #2 clk250 = ~clk250;

  // Reference free-running timestamp, cleared only by reset.
  always @(posedge clk250) begin
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 32'd1;
  end

  task automatic reset_dut();
    rst_n = 1'b0;
    bus.trig_i = 1'b0; bus.phi_i = '0; bus.clear_i = 1'b0; bus.rd_i = 1'b0;
    repeat (2) @(negedge clk250);
    rst_n = 1'b1;
    @(negedge clk250);
  endtask

  task automatic pulse(input logic [31:0] phi);
    bus.phi_i = phi; bus.trig_i = 1'b1;
    @(negedge clk250);
    bus.trig_i = 1'b0;
    @(negedge clk250);
  endtask

  task automatic pop_one();
    bus.rd_i = 1'b1;
    @(negedge clk250);
    bus.rd_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0d want 0", bus.valid_o); end
    checks++; if (bus.count_o !== 3'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", bus.count_o); end
    checks++; if (bus.dropped_o !== 16'd0) begin errors++; $display("[TB] FAIL reset_dropped got %0d want 0", bus.dropped_o); end
    checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %0d want 0", bus.overflow_o); end
    checks++; if (bus.pattern_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_pattern got %h want 0", bus.pattern_o); end
    checks++; if (bus.timestamp_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_timestamp got %0d want 0", bus.timestamp_o); end
    checks++; if (bus.trig_num_o !== 16'd0) begin errors++; $display("[TB] FAIL reset_trig_num got %0d want 0", bus.trig_num_o); end
  endtask

  task automatic test_single();
    for (int i = 0; i < 300 && tb_ts != 32'd100; i++) @(negedge clk250);
    checks++; if (tb_ts !== 32'd100) begin errors++; $display("[TB] FAIL single_wait_ts got %0d want 100", tb_ts); end
    pulse(32'h0003_0000);
    checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %0d want 1", bus.valid_o); end
    checks++; if (bus.pattern_o !== 32'h0003_0000) begin errors++; $display("[TB] FAIL single_pattern got %h want 00030000", bus.pattern_o); end
    checks++; if (bus.timestamp_o !== 32'd100) begin errors++; $display("[TB] FAIL single_timestamp got %0d want 100", bus.timestamp_o); end
    checks++; if (bus.trig_num_o !== 16'd0) begin errors++; $display("[TB] FAIL single_trig_num got %0d want 0", bus.trig_num_o); end
    checks++; if (bus.count_o !== 3'd1) begin errors++; $display("[TB] FAIL single_count got %0d want 1", bus.count_o); end
    pop_one();
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("[TB] FAIL single_pop_valid got %0d want 0", bus.valid_o); end
    checks++; if (bus.count_o !== 3'd0) begin errors++; $display("[TB] FAIL single_pop_count got %0d want 0", bus.count_o); end
  endtask

  task automatic test_level();
    logic [31:0] t0;
    t0 = tb_ts;
    bus.phi_i = 32'h8000_0001; bus.trig_i = 1'b1;
    repeat (10) @(negedge clk250);
    bus.trig_i = 1'b0;
    @(negedge clk250);
    checks++; if (bus.count_o !== 3'd1) begin errors++; $display("[TB] FAIL level_count got %0d want 1", bus.count_o); end
    checks++; if (bus.trig_num_o !== 16'd1) begin errors++; $display("[TB] FAIL level_trig_num got %0d want 1", bus.trig_num_o); end
    checks++; if (bus.timestamp_o !== t0) begin errors++; $display("[TB] FAIL level_timestamp got %0d want %0d", bus.timestamp_o, t0); end
    checks++; if (bus.pattern_o !== 32'h8000_0001) begin errors++; $display("[TB] FAIL level_pattern got %h want 80000001", bus.pattern_o); end
    pop_one();
    pulse(32'h0000_0100);
    checks++; if (bus.trig_num_o !== 16'd2) begin errors++; $display("[TB] FAIL level_next_trig_num got %0d want 2", bus.trig_num_o); end
    pop_one();
  endtask

  task automatic test_overflow();
    reset_dut();
    for (int i = 0; i < 5; i++) pulse(32'h1111_1111 * (i + 1));
    checks++; if (bus.count_o !== 3'd4) begin errors++; $display("[TB] FAIL ovf_count got %0d want 4", bus.count_o); end
    checks++; if (bus.dropped_o !== 16'd1) begin errors++; $display("[TB] FAIL ovf_dropped got %0d want 1", bus.dropped_o); end
    checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got %0d want 1", bus.overflow_o); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("[TB] FAIL ovf_pop_valid[%0d] got %0d want 1", i, bus.valid_o); end
      checks++; if (bus.trig_num_o !== 16'(i)) begin errors++; $display("[TB] FAIL ovf_pop_trig_num[%0d] got %0d want %0d", i, bus.trig_num_o, i); end
      checks++; if (bus.pattern_o !== 32'h1111_1111 * (i + 1)) begin errors++; $display("[TB] FAIL ovf_pop_pattern[%0d] got %h", i, bus.pattern_o); end
      pop_one();
    end
    checks++; if (bus.count_o !== 3'd0) begin errors++; $display("[TB] FAIL ovf_drained_count got %0d want 0", bus.count_o); end
    checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got %0d want 1", bus.overflow_o); end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    for (int i = 0; i < 4; i++) pulse(32'h0000_0010 << i);
    checks++; if (bus.count_o !== 3'd4) begin errors++; $display("[TB] FAIL b2b_fill_count got %0d want 4", bus.count_o); end
    bus.phi_i = 32'hDEAD_BEEF; bus.trig_i = 1'b1; bus.rd_i = 1'b1;
    @(negedge clk250);
    bus.trig_i = 1'b0; bus.rd_i = 1'b0;
    checks++; if (bus.count_o !== 3'd4) begin errors++; $display("[TB] FAIL b2b_count got %0d want 4", bus.count_o); end
    checks++; if (bus.dropped_o !== 16'd0) begin errors++; $display("[TB] FAIL b2b_dropped got %0d want 0", bus.dropped_o); end
    checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overflow got %0d want 0", bus.overflow_o); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (bus.trig_num_o !== 16'(i)) begin errors++; $display("[TB] FAIL b2b_trig_num[%0d] got %0d want %0d", i, bus.trig_num_o, i); end
      pop_one();
    end
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_empty_valid got %0d want 0", bus.valid_o); end
  endtask

  task automatic test_clear();
    logic [31:0] t0;
    reset_dut();
    for (int i = 0; i < 5; i++) pulse(32'h0000_0001 << i);
    pop_one();
    checks++; if (bus.count_o !== 3'd3) begin errors++; $display("[TB] FAIL clr_pre_count got %0d want 3", bus.count_o); end
    bus.clear_i = 1'b1; bus.trig_i = 1'b1; bus.rd_i = 1'b1;
    @(negedge clk250);
    bus.clear_i = 1'b0; bus.rd_i = 1'b0;
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("[TB] FAIL clr_valid got %0d want 0", bus.valid_o); end
    checks++; if (bus.count_o !== 3'd0) begin errors++; $display("[TB] FAIL clr_count got %0d want 0", bus.count_o); end
    checks++; if (bus.dropped_o !== 16'd0) begin errors++; $display("[TB] FAIL clr_dropped got %0d want 0", bus.dropped_o); end
    checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("[TB] FAIL clr_overflow got %0d want 0", bus.overflow_o); end
    @(negedge clk250);
    bus.trig_i = 1'b0;
    @(negedge clk250);
    checks++; if (bus.count_o !== 3'd0) begin errors++; $display("[TB] FAIL clr_no_retrigger got %0d want 0", bus.count_o); end
    t0 = tb_ts;
    pulse(32'h00FF_00FF);
    checks++; if (bus.trig_num_o !== 16'd0) begin errors++; $display("[TB] FAIL clr_trig_num got %0d want 0", bus.trig_num_o); end
    checks++; if (bus.timestamp_o !== t0) begin errors++; $display("[TB] FAIL clr_timestamp got %0d want %0d", bus.timestamp_o, t0); end
    checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("[TB] FAIL clr_post_valid got %0d want 1", bus.valid_o); end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] t0;
    pulse(32'h0F0F_0F0F);
    checks++; if (bus.count_o !== 3'd2) begin errors++; $display("[TB] FAIL rstmid_pre_count got %0d want 2", bus.count_o); end
    rst_n = 1'b0; bus.trig_i = 1'b1; bus.phi_i = 32'hAAAA_5555;
    repeat (2) @(negedge clk250);
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid got %0d want 0", bus.valid_o); end
    checks++; if (bus.count_o !== 3'd0) begin errors++; $display("[TB] FAIL rstmid_count got %0d want 0", bus.count_o); end
    checks++; if (bus.pattern_o !== 32'd0) begin errors++; $display("[TB] FAIL rstmid_pattern got %h want 0", bus.pattern_o); end
    checks++; if (bus.timestamp_o !== 32'd0) begin errors++; $display("[TB] FAIL rstmid_timestamp got %0d want 0", bus.timestamp_o); end
    checks++; if (bus.trig_num_o !== 16'd0) begin errors++; $display("[TB] FAIL rstmid_trig_num got %0d want 0", bus.trig_num_o); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk250);
    checks++; if (bus.count_o !== 3'd0) begin errors++; $display("[TB] FAIL rstmid_held_level got %0d want 0", bus.count_o); end
    bus.trig_i = 1'b0;
    @(negedge clk250);
    t0 = tb_ts;
    pulse(32'h1234_5678);
    checks++; if (bus.count_o !== 3'd1) begin errors++; $display("[TB] FAIL rstmid_fresh_count got %0d want 1", bus.count_o); end
    checks++; if (bus.trig_num_o !== 16'd0) begin errors++; $display("[TB] FAIL rstmid_fresh_trig_num got %0d want 0", bus.trig_num_o); end
    checks++; if (bus.timestamp_o !== t0) begin errors++; $display("[TB] FAIL rstmid_fresh_timestamp got %0d want %0d", bus.timestamp_o, t0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_level();
    test_overflow();
    test_back_to_back();
    test_clear();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
